header_gen: RTL and testbench
=============================

Name: header_gen

Overview:
- Synthesizable, clocked generator of pseudo-random insert headers for the header-insertion datapath.
- Parametrised successor to the behavioural header stimulus source.
- Adds:
  - a valid/ready handshake that holds the header until it is accepted,
  - LFSR-based reproducible randomness with a loadable seed,
  - a programmable inter-header gap,
  - generic data width and keep width.
- Drives the header-insert input of the stream inserter in both the testbench and the FPGA self-test build.

Parameters:
- DATA_WD, 32, header width in bits; multiple of 32, range 32..256.
- DATA_BYTE_WD, DATA_WD/8, keep width in bits.
- GAP_WD, 10, width of the gap configuration and gap counter.
- CNT_WD, 16, width of the accepted-header counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  run request; level-sensitive.
- gap_cfg  in  GAP_WD  number of idle cycles before each header.
- seed_load  in  1  load seed into the LFSR.
- seed  in  32  LFSR seed.
- valid_insert  out  1  header valid.
- ready_insert  in  1  header accepted by downstream.
- keep_insert  out  DATA_BYTE_WD  byte keep, right-aligned ones.
- header_insert  out  DATA_WD  header data.
- hdr_count  out  CNT_WD  count of accepted headers.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, valid_insert=0, keep_insert=0, header_insert=0, hdr_count=0.
  - LFSR=DEFAULT_SEED (32'hACE1_ACE1).
  - Reset mid-transfer drops the pending header immediately.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances one step per accepted header only.
- Header word construction, for i = 0..DATA_WD/32-1:
  - header word i = LFSR state after i+1 further steps, computed combinationally.
  - Word 0 occupies bits [31:0].
- Keep:
  - n = LFSR[15:0] mod (DATA_BYTE_WD+1).
  - keep_insert = low n bits set; n=0 gives all-zero keep.
- States: IDLE, GAP, VALID.
- IDLE:
  - If enable=1 and gap_cfg=0: go to VALID at the next edge.
  - If enable=1 and gap_cfg>0: go to GAP with cnt=gap_cfg-1.
  - gap_cfg is sampled at GAP entry only.
- GAP:
  - cnt decrements each cycle.
  - At cnt=0, go to VALID next edge. Result: exactly gap_cfg idle cycles between the enable sample (or the last handshake) and valid.
  - enable=0 in GAP returns to IDLE next edge.
- VALID:
  - valid_insert=1; keep_insert and header_insert are captured on entry and held stable until handshake (valid_insert & ready_insert).
  - enable falling in VALID does not withdraw valid.
- On handshake:
  - LFSR advances; hdr_count increments, wrapping at 2^CNT_WD.
  - Next state:
    - enable=1, gap_cfg=0: stay in VALID with the new header on the next cycle (back-to-back, one header per cycle).
    - enable=1, gap_cfg>0: go to GAP; valid_insert=0, keep_insert=0, header_insert=0.
    - enable=0: go to IDLE with outputs zeroed.
- ready_insert outside VALID is ignored.
- seed_load:
  - Effective in IDLE and GAP; ignored in VALID so the held header is not disturbed.
  - seed=0 loads DEFAULT_SEED (avoids lock-up).
  - seed_load together with a GAP→VALID transition: the load takes effect first, and the captured header uses the new seed.

Optional Feature:
- Macro HEADER_GEN_NONZERO_KEEP_EN.
- Defined: n = (LFSR[15:0] mod DATA_BYTE_WD) + 1; keep is never zero.
- Undefined: n ranges 0..DATA_BYTE_WD as above.

Decomposition:
- Package header_gen_pkg holds:
  - state enum type (IDLE, GAP, VALID),
  - LFSR polynomial constant,
  - DEFAULT_SEED,
  - function lfsr_next,
  - function keep_from_n.
- One sub-module, header_lfsr: 32-bit LFSR with seed load, zero-seed substitution, advance strobe and unrolled look-ahead outputs.

Test Plan:
- Reset with enable=1, gap_cfg=3, ready tied 1 → valid high on the 4th cycle after reset release; thereafter 1-cycle valid pulses separated by 3 idle cycles; hdr_count=5 after 5 pulses.
- seed=32'h1, ready=0 for 7 cycles after valid → header_insert and keep_insert stay constant all 7 cycles, hdr_count unchanged; on ready=1, one handshake and hdr_count+1.
- gap_cfg=0, enable=1, ready=1 → valid high every cycle; headers match the reference-model LFSR sequence for 1000 beats.
- enable dropped while VALID with ready=0 → valid held until ready=1, then IDLE with outputs zero.
- seed_load with seed=0 → sequence identical to post-reset sequence.
- DATA_WD=128 → keep spans 0..16 over 10k headers with each value hit.
- With HEADER_GEN_NONZERO_KEEP_EN defined → keep is never 0.

Source files
------------

// File: rtl/header_gen_pkg.sv
// Shared types and helpers for the pseudo-random header generator.
// Holds the FSM state type, LFSR constants and the step/keep helper functions.
package header_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        VALID = 2'd2
    } state_e;

    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_ACE1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [31:0] keep_from_n(input logic [5:0] n);
        logic [32:0] t;
        t = (33'd1 << n) - 33'd1;
        return t[31:0];
    endfunction

endpackage

// File: rtl/header_lfsr.sv
// 32-bit Galois LFSR with seed load (zero seed replaced by the default) and advance strobe.
// words_o and keep_src_o are look-ahead views of the state the register takes at the next edge.
module header_lfsr
    import header_gen_pkg::*;
#(
    parameter int NWORDS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seed_load_i,
    input  logic [31:0]           seed_i,
    input  logic                  advance_i,
    output logic [NWORDS*32-1:0]  words_o,
    output logic [15:0]           keep_src_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] walk;

    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load_i) begin
            lfsr_d = (seed_i == 32'h0) ? DEFAULT_SEED : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= DEFAULT_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Word i is the state i+1 steps beyond the upcoming register value
    always_comb begin
        walk    = lfsr_d;
        words_o = '0;
        for (int i = 0; i < NWORDS; i++) begin
            walk                = lfsr_next(walk);
            words_o[32*i +: 32] = walk;
        end
    end

    assign keep_src_o = lfsr_d[15:0];

endmodule

// File: rtl/header_gen.sv
// Pseudo-random insert-header source with valid/ready hold, loadable LFSR seed and programmable gap.
// Optional HEADER_GEN_NONZERO_KEEP_EN: keep length drawn from 1..DATA_BYTE_WD instead of 0..DATA_BYTE_WD.
module header_gen
    import header_gen_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int GAP_WD       = 10,
    parameter int CNT_WD       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [GAP_WD-1:0]       gap_cfg,
    input  logic                    seed_load,
    input  logic [31:0]             seed,
    output logic                    valid_insert,
    input  logic                    ready_insert,
    output logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic [DATA_WD-1:0]      header_insert,
    output logic [CNT_WD-1:0]       hdr_count
);

    localparam int NWORDS = DATA_WD / 32;

    state_e                  state_q, state_d;
    logic [GAP_WD-1:0]       cnt_q, cnt_d;
    logic [CNT_WD-1:0]       hcnt_q, hcnt_d;
    logic [DATA_WD-1:0]      hdr_q, hdr_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;

    logic                    handshake;
    logic                    load_ok;
    logic                    capture;
    logic                    clear;
    logic [DATA_WD-1:0]      words_nx;
    logic [15:0]             keep_src;
    logic [5:0]              keep_n;

    assign handshake = (state_q == VALID) && ready_insert;
    // The held header must not change under a seed load
    assign load_ok   = seed_load && (state_q != VALID);

    header_lfsr #(
        .NWORDS (NWORDS)
    ) u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .seed_load_i (load_ok),
        .seed_i      (seed),
        .advance_i   (handshake),
        .words_o     (words_nx),
        .keep_src_o  (keep_src)
    );

    always_comb begin
`ifdef HEADER_GEN_NONZERO_KEEP_EN
        keep_n = 6'(keep_src % 16'(DATA_BYTE_WD)) + 6'd1;
`else
        keep_n = 6'(keep_src % 16'(DATA_BYTE_WD + 1));
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        capture = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (gap_cfg == '0) begin
                        state_d = VALID;
                        capture = 1'b1;
                    end else begin
                        state_d = GAP;
                        cnt_d   = gap_cfg - GAP_WD'(1);
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = VALID;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - GAP_WD'(1);
                end
            end
            VALID: begin
                if (handshake) begin
                    hcnt_d = hcnt_q + CNT_WD'(1);
                    if (enable && (gap_cfg == '0)) begin
                        capture = 1'b1;
                    end else if (enable) begin
                        state_d = GAP;
                        cnt_d   = gap_cfg - GAP_WD'(1);
                        clear   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        clear   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        hdr_d  = hdr_q;
        keep_d = keep_q;
        if (capture) begin
            hdr_d  = words_nx;
            keep_d = DATA_BYTE_WD'(keep_from_n(keep_n));
        end else if (clear) begin
            hdr_d  = '0;
            keep_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            hdr_q   <= '0;
            keep_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            hdr_q   <= hdr_d;
            keep_q  <= keep_d;
        end
    end

    assign valid_insert  = (state_q == VALID);
    assign keep_insert   = keep_q;
    assign header_insert = hdr_q;
    assign hdr_count     = hcnt_q;

endmodule

// File: tb/tb_header_gen.sv
// Directed bench for header_gen at DATA_WD=128; hand-computed headers plus an independent LFSR model.
module tb_header_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [9:0]   gap_cfg;
    logic         seed_load;
    logic [31:0]  seed;
    logic         valid_insert;
    logic         ready_insert;
    logic [15:0]  keep_insert;
    logic [127:0] header_insert;
    logic [15:0]  hdr_count;

    int checks = 0;
    int errors = 0;

`ifdef HEADER_GEN_NONZERO_KEEP_EN
    localparam logic [15:0] KEEP_DEF   = 16'h0003;
    localparam logic [15:0] KEEP_SEED1 = 16'h0003;
`else
    localparam logic [15:0] KEEP_DEF   = 16'h003F;
    localparam logic [15:0] KEEP_SEED1 = 16'h0001;
`endif

    header_gen #(
        .DATA_WD      (128),
        .DATA_BYTE_WD (16),
        .GAP_WD       (10),
        .CNT_WD       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .gap_cfg       (gap_cfg),
        .seed_load     (seed_load),
        .seed          (seed),
        .valid_insert  (valid_insert),
        .ready_insert  (ready_insert),
        .keep_insert   (keep_insert),
        .header_insert (header_insert),
        .hdr_count     (hdr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [127:0] m_hdr(input logic [31:0] s);
        logic [127:0] h;
        logic [31:0]  w;
        w = s;
        for (int i = 0; i < 4; i++) begin
            w = m_step(w);
            h[32*i +: 32] = w;
        end
        return h;
    endfunction

    function automatic logic [15:0] m_keep(input logic [31:0] s);
        int n;
`ifdef HEADER_GEN_NONZERO_KEEP_EN
        n = (int'(s[15:0]) % 16) + 1;
`else
        n = int'(s[15:0]) % 17;
`endif
        return 16'((32'd1 << n) - 32'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; gap_cfg = 10'd3; ready_insert = 1'b1;
        seed_load = 1'b0; seed = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_insert); end
        checks++; if (keep_insert !== 16'h0) begin errors++; $display("FAIL reset_keep got=%h exp=0000", keep_insert); end
        checks++; if (header_insert !== 128'h0) begin errors++; $display("FAIL reset_header got=%h exp=0", header_insert); end
        checks++; if (hdr_count !== 16'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", hdr_count); end
    endtask

    task automatic test_gap_pulses();
        logic [31:0] m;
        logic        exp_v;
        m = 32'hACE1_ACE1;
        rst = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp_v = (k % 4 == 0);
            checks++; if (valid_insert !== exp_v) begin errors++; $display("FAIL gap_valid cycle=%0d got=%b exp=%b", k, valid_insert, exp_v); end
            if (k == 4) begin
                checks++; if (header_insert[63:0] !== 64'hEB086B3A_D650D673) begin errors++; $display("FAIL gap_first_hdr got=%h exp=eb086b3ad650d673", header_insert[63:0]); end
                checks++; if (keep_insert !== KEEP_DEF) begin errors++; $display("FAIL gap_first_keep got=%h exp=%h", keep_insert, KEEP_DEF); end
            end
            if (exp_v) begin
                checks++; if (header_insert !== m_hdr(m)) begin errors++; $display("FAIL gap_hdr cycle=%0d got=%h exp=%h", k, header_insert, m_hdr(m)); end
                checks++; if (keep_insert !== m_keep(m)) begin errors++; $display("FAIL gap_keep cycle=%0d got=%h exp=%h", k, keep_insert, m_keep(m)); end
                m = m_step(m);
            end else begin
                checks++; if (header_insert !== 128'h0) begin errors++; $display("FAIL gap_idle_hdr cycle=%0d got=%h exp=0", k, header_insert); end
            end
        end
        checks++; if (hdr_count !== 16'd5) begin errors++; $display("FAIL gap_count got=%0d exp=5", hdr_count); end
    endtask

    task automatic test_hold();
        enable = 1'b0; ready_insert = 1'b0;
        tick(); tick();
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b exp=0", valid_insert); end
        seed_load = 1'b1; seed = 32'h1;
        tick();
        seed_load = 1'b0; gap_cfg = 10'd0; enable = 1'b1;
        tick();
        checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b exp=1", valid_insert); end
        checks++; if (header_insert[63:0] !== 64'hC0300002_80200003) begin errors++; $display("FAIL hold_hdr_hand got=%h exp=c030000280200003", header_insert[63:0]); end
        checks++; if (header_insert !== m_hdr(32'h1)) begin errors++; $display("FAIL hold_hdr got=%h exp=%h", header_insert, m_hdr(32'h1)); end
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin seed_load = 1'b1; seed = 32'hDEAD_BEEF; end
            if (i == 4) enable = 1'b0;
            tick();
            checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL hold_valid_held cycle=%0d got=%b exp=1", i, valid_insert); end
            checks++; if (header_insert !== m_hdr(32'h1)) begin errors++; $display("FAIL hold_hdr_stable cycle=%0d got=%h exp=%h", i, header_insert, m_hdr(32'h1)); end
            checks++; if (keep_insert !== KEEP_SEED1) begin errors++; $display("FAIL hold_keep_stable cycle=%0d got=%h exp=%h", i, keep_insert, KEEP_SEED1); end
            checks++; if (hdr_count !== 16'd5) begin errors++; $display("FAIL hold_count cycle=%0d got=%0d exp=5", i, hdr_count); end
        end
        seed_load = 1'b0; ready_insert = 1'b1;
        tick();
        ready_insert = 1'b0;
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp=0", valid_insert); end
        checks++; if (header_insert !== 128'h0) begin errors++; $display("FAIL hold_release_hdr got=%h exp=0", header_insert); end
        checks++; if (keep_insert !== 16'h0) begin errors++; $display("FAIL hold_release_keep got=%h exp=0000", keep_insert); end
        checks++; if (hdr_count !== 16'd6) begin errors++; $display("FAIL hold_release_count got=%0d exp=6", hdr_count); end
    endtask

    task automatic test_seed_at_valid();
        gap_cfg = 10'd2; enable = 1'b1; ready_insert = 1'b0;
        tick();
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL sv_gap1 got=%b exp=0", valid_insert); end
        tick();
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL sv_gap2 got=%b exp=0", valid_insert); end
        tick();
        checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL sv_valid1 got=%b exp=1", valid_insert); end
        checks++; if (header_insert[31:0] !== 32'hC0300002) begin errors++; $display("FAIL sv_hdr1 got=%h exp=c0300002", header_insert[31:0]); end
        checks++; if (header_insert !== m_hdr(32'h8020_0003)) begin errors++; $display("FAIL sv_hdr1_full got=%h exp=%h", header_insert, m_hdr(32'h8020_0003)); end
        ready_insert = 1'b1;
        tick();
        ready_insert = 1'b0;
        checks++; if (valid_insert !== 1'b0 || header_insert !== 128'h0) begin errors++; $display("FAIL sv_regap got=%b/%h exp=0/0", valid_insert, header_insert); end
        tick();
        seed_load = 1'b1; seed = 32'h1234_5678;
        tick();
        seed_load = 1'b0;
        checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL sv_valid2 got=%b exp=1", valid_insert); end
        checks++; if (header_insert[31:0] !== 32'h091A2B3C) begin errors++; $display("FAIL sv_hdr2 got=%h exp=091a2b3c", header_insert[31:0]); end
        checks++; if (header_insert !== m_hdr(32'h1234_5678)) begin errors++; $display("FAIL sv_hdr2_full got=%h exp=%h", header_insert, m_hdr(32'h1234_5678)); end
        enable = 1'b0; ready_insert = 1'b1;
        tick();
        ready_insert = 1'b0;
        checks++; if (hdr_count !== 16'd8) begin errors++; $display("FAIL sv_count got=%0d exp=8", hdr_count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] m;
        logic [16:0] hit;
        logic        exp_hit;
        hit = '0;
        m = 32'hACE1_ACE1;
        seed_load = 1'b1; seed = 32'h0;
        tick();
        seed_load = 1'b0; gap_cfg = 10'd0; enable = 1'b1; ready_insert = 1'b1;
        tick();
        checks++; if (header_insert[31:0] !== 32'hD650D673) begin errors++; $display("FAIL b2b_first got=%h exp=d650d673", header_insert[31:0]); end
        for (int i = 0; i < 1000; i++) begin
            checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL b2b_valid beat=%0d got=%b exp=1", i, valid_insert); end
            checks++; if (header_insert !== m_hdr(m)) begin errors++; $display("FAIL b2b_hdr beat=%0d got=%h exp=%h", i, header_insert, m_hdr(m)); end
            checks++; if (keep_insert !== m_keep(m)) begin errors++; $display("FAIL b2b_keep beat=%0d got=%h exp=%h", i, keep_insert, m_keep(m)); end
            hit[$countones(keep_insert)] = 1'b1;
            m = m_step(m);
            if (i == 999) enable = 1'b0;
            tick();
        end
        ready_insert = 1'b0;
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b exp=0", valid_insert); end
        checks++; if (hdr_count !== 16'd1008) begin errors++; $display("FAIL b2b_count got=%0d exp=1008", hdr_count); end
        for (int n = 0; n <= 16; n++) begin
`ifdef HEADER_GEN_NONZERO_KEEP_EN
            exp_hit = (n != 0);
`else
            exp_hit = 1'b1;
`endif
            checks++; if (hit[n] !== exp_hit) begin errors++; $display("FAIL keep_cover n=%0d got=%b exp=%b", n, hit[n], exp_hit); end
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; gap_cfg = 10'd0; ready_insert = 1'b0;
        tick();
        checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL mid_valid got=%b exp=1", valid_insert); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid_insert !== 1'b0) begin errors++; $display("FAIL mid_drop_valid got=%b exp=0", valid_insert); end
        checks++; if (header_insert !== 128'h0) begin errors++; $display("FAIL mid_drop_hdr got=%h exp=0", header_insert); end
        checks++; if (hdr_count !== 16'h0) begin errors++; $display("FAIL mid_drop_count got=%0d exp=0", hdr_count); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (valid_insert !== 1'b1) begin errors++; $display("FAIL mid_restart_valid got=%b exp=1", valid_insert); end
        checks++; if (header_insert[31:0] !== 32'hD650D673) begin errors++; $display("FAIL mid_restart_hdr got=%h exp=d650d673", header_insert[31:0]); end
        checks++; if (keep_insert !== KEEP_DEF) begin errors++; $display("FAIL mid_restart_keep got=%h exp=%h", keep_insert, KEEP_DEF); end
    endtask

    initial begin
        test_reset();
        test_gap_pulses();
        test_hold();
        test_seed_at_valid();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
